// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the PC and the four pipeline stage registers.
// Each cycle it decides enable/clear for every stage, covering load-use stalls,
// redirect flushes, data-memory wait freezes and multi-cycle EX holds.
// It also counts cycles in which the PC is frozen.
module pipeline_hazard_ctrl #(
  parameter int MC_CYCLES   = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             d_rs1,
  input  logic [4:0]             d_rs2,
  input  logic                   d_uses_rs1,
  input  logic                   d_uses_rs2,
  input  logic [4:0]             e_rd,
  input  logic                   e_mem_read,
  input  logic                   e_redirect,
  input  logic                   e_multicycle,
  input  logic                   m_dmem_wait,
  output logic                   f_pc_en,
  output logic                   fd_en,
  output logic                   fd_clear,
  output logic                   de_en,
  output logic                   de_clear,
  output logic                   em_en,
  output logic                   em_clear,
  output logic                   mw_en,
  output logic                   mw_clear,
  output logic                   mc_start,
  output logic                   mc_done,
  output logic                   ex_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = $clog2(MC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_cnt_zero;
  logic w_pc_en, w_fd_en, w_fd_clear, w_de_en, w_de_clear;
  logic w_em_en, w_em_clear, w_mw_en, w_mw_clear;
  logic w_mc_start, w_mc_done, w_ex_busy;

  // A load in EX whose (non-x0) destination is read by the instruction in ID.
  assign w_load_use = e_mem_read && (e_rd != 5'd0) &&
                      ((d_uses_rs1 && (d_rs1 == e_rd)) ||
                       (d_uses_rs2 && (d_rs2 == e_rd)));
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state and stage-control decode; rules are checked in priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_fd_en     = 1'b1;
    w_fd_clear  = 1'b0;
    w_de_en     = 1'b1;
    w_de_clear  = 1'b0;
    w_em_en     = 1'b1;
    w_em_clear  = 1'b0;
    w_mw_en     = 1'b1;
    w_mw_clear  = 1'b0;
    w_mc_start  = 1'b0;
    w_mc_done   = 1'b0;
    w_ex_busy   = 1'b0;

    if (reset) begin
      // Hold everything and flush every stage; an in-flight multi-cycle op is dropped.
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
      w_pc_en     = 1'b0;
      w_fd_en     = 1'b0;
      w_de_en     = 1'b0;
      w_em_en     = 1'b0;
      w_mw_en     = 1'b0;
      w_fd_clear  = 1'b1;
      w_de_clear  = 1'b1;
      w_em_clear  = 1'b1;
      w_mw_clear  = 1'b1;
    end else begin
      w_ex_busy = (r_state == ST_MULTI);
      w_mc_done = (r_state == ST_MULTI) && w_cnt_zero;

      // FSM evolution: a memory wait blocks both issue and exit, not the countdown.
      case (r_state)
        ST_RUN: begin
          if (e_multicycle && !m_dmem_wait) begin
            w_state_nxt = ST_MULTI;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MULTI: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (!m_dmem_wait) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_MULTI;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase

      // Stage controls.
      if (m_dmem_wait) begin
        // Freeze the whole pipe; WB gets a bubble so a stalled write is not repeated.
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_de_en    = 1'b0;
        w_em_en    = 1'b0;
        w_mw_en    = 1'b0;
        w_mw_clear = 1'b1;
      end else if ((r_state == ST_MULTI) && !w_cnt_zero) begin
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_de_en    = 1'b0;
        w_em_clear = 1'b1;
      end else if (r_state == ST_MULTI) begin
        // Final cycle: result leaves EX, everything advances.
        w_pc_en = 1'b1;
      end else if (e_multicycle) begin
        w_mc_start = 1'b1;
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_de_en    = 1'b0;
        w_em_clear = 1'b1;
      end else if (e_redirect) begin
        // Wrong-path instructions in IF/ID and ID/EX are squashed.
        w_fd_clear = 1'b1;
        w_de_clear = 1'b1;
      end else if (w_load_use) begin
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_de_clear = 1'b1;
      end else begin
        w_pc_en = 1'b1;
      end
    end
  end

  // FSM state and multi-cycle countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Free-running count of PC-frozen cycles; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_en) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign f_pc_en     = w_pc_en;
  assign fd_en       = w_fd_en;
  assign fd_clear    = w_fd_clear;
  assign de_en       = w_de_en;
  assign de_clear    = w_de_clear;
  assign em_en       = w_em_en;
  assign em_clear    = w_em_clear;
  assign mw_en       = w_mw_en;
  assign mw_clear    = w_mw_clear;
  assign mc_start    = w_mc_start;
  assign mc_done     = w_mc_done;
  assign ex_busy     = w_ex_busy;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl (MC_CYCLES=4, 4-bit stall counter).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic       d_uses_rs1, d_uses_rs2, e_mem_read, e_redirect, e_multicycle, m_dmem_wait;
  logic       f_pc_en, fd_en, fd_clear, de_en, de_clear, em_en, em_clear, mw_en, mw_clear;
  logic       mc_start, mc_done, ex_busy;
  logic [3:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_CYCLES(4), .STALL_CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd(e_rd), .e_mem_read(e_mem_read), .e_redirect(e_redirect),
    .e_multicycle(e_multicycle), .m_dmem_wait(m_dmem_wait),
    .f_pc_en(f_pc_en), .fd_en(fd_en), .fd_clear(fd_clear), .de_en(de_en), .de_clear(de_clear),
    .em_en(em_en), .em_clear(em_clear), .mw_en(mw_en), .mw_clear(mw_clear),
    .mc_start(mc_start), .mc_done(mc_done), .ex_busy(ex_busy), .stall_count(stall_count)
  );

  // Output vector bit order:
  // {pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, mc_start, mc_done, ex_busy}
  localparam logic [11:0] O_RST   = 12'b001010101000;
  localparam logic [11:0] O_DEF   = 12'b110101010000;
  localparam logic [11:0] O_LU    = 12'b000111010000;
  localparam logic [11:0] O_REDIR = 12'b111111010000;
  localparam logic [11:0] O_ISSUE = 12'b000001110100;
  localparam logic [11:0] O_BUSY  = 12'b000001110001;
  localparam logic [11:0] O_DONE  = 12'b110101010011;
  localparam logic [11:0] O_WRUN  = 12'b000000001000;
  localparam logic [11:0] O_WMC0  = 12'b000000001011;
  localparam logic [11:0] O_WMCB  = 12'b000000001001;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       redir;
    logic       mc;
    logic       wt;
    logic [11:0] exp_o;
    logic [3:0]  exp_sc;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic mrd, input logic redir, input logic mc, input logic wt,
                              input logic [11:0] eo, input logic [3:0] esc);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mrd = mrd; v.redir = redir; v.mc = mc; v.wt = wt; v.exp_o = eo; v.exp_sc = esc;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {f_pc_en, fd_en, fd_clear, de_en, de_clear, em_en, em_clear, mw_en, mw_clear,
            mc_start, mc_done, ex_busy};
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; d_rs1 = v.rs1; d_rs2 = v.rs2; d_uses_rs1 = v.u1; d_uses_rs2 = v.u2;
    e_rd = v.rd; e_mem_read = v.mrd; e_redirect = v.redir; e_multicycle = v.mc;
    m_dmem_wait = v.wt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    //               rst rs1 rs2 u1 u2 rd mrd rdr mc wt  outs     sc
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   4'd0));  // 0 reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   4'd0));  // 1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   4'd0));  // 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd0));  // 3 idle
    vecs.push_back(mk(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, O_LU,    4'd0));  // 4 load-use rs2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd1));  // 5 stall was 1 cycle
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, O_DEF,   4'd1));  // 6 rd=x0 no stall
    vecs.push_back(mk(0, 7, 0, 1, 0, 7, 1, 0, 0, 0, O_LU,    4'd1));  // 7 load-use rs1
    vecs.push_back(mk(0, 7, 3, 0, 1, 7, 1, 0, 0, 0, O_DEF,   4'd2));  // 8 rs1 not used
    vecs.push_back(mk(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, O_REDIR, 4'd2));  // 9 redirect beats load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd2));  // 10 count unchanged
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ISSUE, 4'd2));  // 11 mc issue
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BUSY,  4'd3));  // 12 cnt3, redirect ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  4'd4));  // 13 cnt2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd5));  // 14 cnt1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DONE,  4'd6));  // 15 cnt0 done
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd6));  // 16 back in RUN
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ISSUE, 4'd6));  // 17 issue
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd7));  // 18
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd8));  // 19
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd9));  // 20
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_WMC0,  4'd10)); // 21 wait at cnt0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_WMC0,  4'd11)); // 22
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_WMC0,  4'd12)); // 23
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DONE,  4'd13)); // 24 exit after wait
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd13)); // 25 no re-pulse
    vecs.push_back(mk(0, 0, 5, 0, 1, 5, 1, 1, 1, 1, O_WRUN,  4'd13)); // 26 wait beats all in RUN
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd14)); // 27 no issue happened
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ISSUE, 4'd14)); // 28 issue
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_WMCB,  4'd15)); // 29 wait at cnt3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd0));  // 30 cnt2, counter wrapped
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4'd1));  // 31 cnt1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DONE,  4'd2));  // 32 cnt0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd2));  // 33
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ISSUE, 4'd2));  // 34 issue
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   4'd3));  // 35 reset mid-MULTI
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   4'd0));  // 36 aborted, RUN

    // One unchecked reset edge so the counter holds a known value.
    apply(vecs[0]);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_stall", i), 32'(stall_count), 32'(vecs[i].exp_sc));
    end

    // Hand sequence: issue, then wait (bounded) for mc_done counting edges and start pulses.
    begin
      int cycles;
      int starts;
      bit seen;
      @(negedge clk);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ISSUE, 4'd0));
      #2;
      starts = mc_start ? 1 : 0;
      cycles = 0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        e_multicycle = 1'b1;  // a new mc request in EX must not restart the unit
        #2;
        cycles++;
        if (mc_start) starts++;
        if (mc_done) seen = 1'b1;
      end
      check("seq_done_seen", 32'(seen), 32'd1);
      check("seq_done_latency", 32'(cycles), 32'd4);
      check("seq_start_pulses", 32'(starts), 32'd1);
      @(negedge clk);
      e_multicycle = 1'b0;
      #2;
      check("seq_back_to_run", 32'(outs()), 32'(O_DEF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
